seg_scan_decoder: RTL

//  Receive-side counterpart of the nibble-to-7-segment encoder: samples multiplexed 7-seg lines
//  (segment bus + one-hot digit select) and reconstructs the displayed hex value. Each digit is

---
 rtl/seg_scan_decoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side decoder for a multiplexed 7-segment display. It samples the segment bus and the
//   one-hot digit select, waits for each digit to be stable, decodes the glyph back to a nibble
//   and publishes a complete frame with a 1-cycle valid strobe.
//
//   Build option: define SEGDEC_CHANGE_ONLY_EN to strobe value_valid only when the published
//   value or error set changes. The first frame after reset always strobes.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   seg_in      segment lines, bit0=a .. bit6=g, active-high, asynchronous
//   dig_sel     one-hot digit enable, bit i = digit i, asynchronous
//   value_out   published value, nibble i = digit i
//   value_valid 1-cycle strobe when value_out is updated
//   digit_err   per digit: last published pattern was not a legal glyph
//   frame_err   OR of digit_err
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   value_out,
  output logic                  value_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_err
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  state_t state, next_state;

  logic [6:0]              seg_s1, s_seg, prev_seg;
  logic [DIGITS-1:0]       dig_s1, s_dig, prev_dig;
  logic [RW-1:0]           run, run_next;
  logic [DIGITS-1:0]       mask, mask_base;
  logic [DIGITS-1:0][3:0]  staged_nib;
  logic [DIGITS-1:0]       staged_err;
  logic [IW-1:0]           idx;
  logic                    onehot, capture, publish, pub_strobe;
  logic [4:0]              dec;

  // {err, nibble}; anything that is not one of the 16 hex glyphs decodes to 0 with err set
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h27: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (s_dig[i]) idx = IW'(i);
  end

  assign onehot = $onehot(s_dig);
  assign dec    = decode(s_seg);

  // Run length of the current (dig, seg) pair; held at zero while the select is not one-hot
  always_comb begin
    run_next = run;
    if (!onehot)
      run_next = '0;
    else if (s_dig != prev_dig || s_seg != prev_seg)
      run_next = RW'(1);
    else if (run != RUN_MAX)
      run_next = run + 1'b1;
  end

  // Only the cycle the run first hits the threshold captures, so one capture per dwell
  assign capture   = onehot && (run_next == RUN_MAX) && (run != RUN_MAX);
  assign mask_base = (state == PUBLISH) ? '0 : mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1     <= '0;
      s_seg      <= '0;
      prev_seg   <= '0;
      dig_s1     <= '0;
      s_dig      <= '0;
      prev_dig   <= '0;
      run        <= '0;
      mask       <= '0;
      staged_nib <= '0;
      staged_err <= '0;
    end else begin
      seg_s1   <= seg_in;
      s_seg    <= seg_s1;
      prev_seg <= s_seg;
      dig_s1   <= dig_sel;
      s_dig    <= dig_s1;
      prev_dig <= s_dig;
      run      <= run_next;
      // A capture in the publish cycle lands after the clear and counts toward the next frame
      mask     <= capture ? (mask_base | (DIGITS'(1) << idx)) : mask_base;
      if (capture) begin
        staged_nib[idx] <= dec[3:0];
        staged_err[idx] <= dec[4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= next_state;
  end

`ifdef SEGDEC_CHANGE_ONLY_EN
  logic pub_once;

  always_ff @(posedge clk) begin
    if (rst)          pub_once <= 1'b0;
    else if (publish) pub_once <= 1'b1;
  end

  assign pub_strobe = !pub_once || (value_out != staged_nib) || (digit_err != staged_err);
`else
  assign pub_strobe = 1'b1;
`endif

  always_comb begin
    next_state = state;
    publish    = 1'b0;
    case (state)
      COLLECT: if (&mask) next_state = PUBLISH;
      PUBLISH: begin
        publish    = 1'b1;
        next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_out   <= '0;
      value_valid <= 1'b0;
      digit_err   <= '0;
      frame_err   <= 1'b0;
    end else begin
      value_valid <= publish && pub_strobe;
      if (publish) begin
        value_out <= staged_nib;
        digit_err <= staged_err;
        frame_err <= |staged_err;
      end
    end
  end

endmodule
